// File: rtl/mole_scheduler.sv
// rtl/mole_scheduler.sv - whack-a-mole round scheduler, optional lit-time speed-up under MOLE_SPEEDUP_EN
module mole_scheduler #(
    parameter int UP_TICKS     = 8,
    parameter int GAP_TICKS    = 2,
    parameter int ROUNDS       = 16,
    parameter int MIN_UP_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic [7:0] btn,
    output logic [7:0] mole,
    output logic [7:0] score,
    output logic [7:0] miss,
    output logic       busy,
    output logic       game_over
);
    typedef enum logic [2:0] {IDLE, SPAWN, UP, HIT, GAP, OVER} state_t;

    // The lit time never starts below the speed-up floor.
    localparam logic [7:0] UP_T     = 8'((UP_TICKS > MIN_UP_TICKS) ? UP_TICKS : MIN_UP_TICKS);
    localparam logic [7:0] GAP_T    = 8'(GAP_TICKS);
    localparam logic [7:0] ROUNDS_T = 8'(ROUNDS);

    state_t     state, state_nx;
    logic [7:0] lfsr;
    logic [7:0] timer, timer_nx;
    logic [7:0] rnd, rnd_nx;
    logic [7:0] btn_q, rise;
    logic [7:0] score_nx, miss_nx, mole_nx;
    logic [7:0] lit_time;
    logic [2:0] idx, idx_nx, spawn_idx;
    logic       lit_rise, expire, busy_nx, over_nx;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign rise      = btn & ~btn_q;
    assign lit_rise  = rise[idx];
    assign expire    = tick && (timer <= 8'd1);
    // idx holds the previous round's pick until SPAWN overwrites it.
    assign spawn_idx = (lfsr[2:0] == idx) ? lfsr[2:0] + 3'd1 : lfsr[2:0];

`ifdef MOLE_SPEEDUP_EN
    localparam logic [7:0] MIN_T = 8'(MIN_UP_TICKS);
    logic [7:0] lit_q, lit_nx;

    always_comb begin
        lit_nx = lit_q;
        if ((state == IDLE || state == OVER) && start)
            lit_nx = UP_T;
        else if (state == UP && lit_rise && score != 8'hFF &&
                 score_nx[1:0] == 2'd0 && lit_q > MIN_T)
            lit_nx = lit_q - 8'd1;
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst)
            lit_q <= UP_T;
        else
            lit_q <= lit_nx;
    end

    assign lit_time = lit_q;
`else
    assign lit_time = UP_T;
`endif

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lfsr      <= 8'hA5;
            timer     <= 8'd0;
            rnd       <= 8'd0;
            idx       <= 3'd0;
            btn_q     <= 8'd0;
            score     <= 8'd0;
            miss      <= 8'd0;
            mole      <= 8'd0;
            busy      <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_nx;
            lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            timer     <= timer_nx;
            rnd       <= rnd_nx;
            idx       <= idx_nx;
            btn_q     <= btn;
            score     <= score_nx;
            miss      <= miss_nx;
            mole      <= mole_nx;
            busy      <= busy_nx;
            game_over <= over_nx;
        end
    end

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        rnd_nx   = rnd;
        idx_nx   = idx;
        score_nx = score;
        miss_nx  = miss;
        case (state)
            IDLE, OVER: begin
                if (start) begin
                    score_nx = 8'd0;
                    miss_nx  = 8'd0;
                    rnd_nx   = 8'd0;
                    state_nx = SPAWN;
                end
            end
            SPAWN: begin
                idx_nx   = spawn_idx;
                timer_nx = lit_time;
                state_nx = UP;
            end
            UP: begin
                // A correct hit wins over expiry and wrong presses in the same cycle.
                if (lit_rise) begin
                    score_nx = sat_inc(score);
                    timer_nx = GAP_T;
                    state_nx = HIT;
                end else if (expire) begin
                    miss_nx  = sat_inc(miss);
                    timer_nx = GAP_T;
                    state_nx = GAP;
                end else begin
                    if (tick)
                        timer_nx = timer - 8'd1;
                    if (rise != 8'd0)
                        miss_nx = sat_inc(miss);
                end
            end
            HIT: state_nx = GAP;
            GAP: begin
                if (tick) begin
                    if (timer <= 8'd1) begin
                        timer_nx = 8'd0;
                        rnd_nx   = rnd + 8'd1;
                        state_nx = (rnd + 8'd1 == ROUNDS_T) ? OVER : SPAWN;
                    end else begin
                        timer_nx = timer - 8'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        mole_nx = (state_nx == UP) ? (8'd1 << idx_nx) : 8'd0;
        busy_nx = !(state_nx == IDLE || state_nx == OVER);
        over_nx = (state_nx == OVER);
    end
endmodule

// File: tb/tb_mole_scheduler.sv
// tb/tb_mole_scheduler.sv - scoreboard bench for mole_scheduler
module tb_mole_scheduler;
`ifdef MOLE_SPEEDUP_EN
    localparam int TB_ROUNDS = 6;
`else
    localparam int TB_ROUNDS = 3;
`endif
    localparam int MK_ZERO = 0, MK_ONEHOT = 1, MK_DIFF = 2, MK_EXACT = 3;

    logic       clk = 1'b1;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic [7:0] btn = 8'd0;
    logic [7:0] mole, score, miss;
    logic       busy, game_over;

    mole_scheduler #(
        .UP_TICKS(8), .GAP_TICKS(2), .ROUNDS(TB_ROUNDS), .MIN_UP_TICKS(2)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .btn(btn),
        .mole(mole), .score(score), .miss(miss), .busy(busy), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         at;
        logic [7:0] score;
        logic [7:0] miss;
        logic       busy;
        logic       over;
        int         mkind;
        logic [7:0] mref;
    } exp_t;

    exp_t q[$];
    int   pcnt   = 0;
    int   checks = 0;
    int   errors = 0;

    function automatic logic mole_ok(input logic [7:0] m, input int k, input logic [7:0] r);
        logic onehot;
        onehot = (m != 8'd0) && ((m & (m - 8'd1)) == 8'd0);
        case (k)
            MK_ZERO:   return m == 8'd0;
            MK_ONEHOT: return onehot;
            MK_DIFF:   return onehot && (m != r);
            default:   return m == r;
        endcase
    endfunction

    exp_t mon_e;
    logic mon_ok;
    always @(posedge clk) begin
        pcnt = pcnt + 1;
        while (q.size() > 0 && q[0].at <= pcnt) begin
            mon_e  = q.pop_front();
            checks = checks + 1;
            mon_ok = (mon_e.at == pcnt) && (score == mon_e.score) && (miss == mon_e.miss) &&
                     (busy == mon_e.busy) && (game_over == mon_e.over) &&
                     mole_ok(mole, mon_e.mkind, mon_e.mref);
            if (!mon_ok) begin
                errors = errors + 1;
                $display("FAIL %s: got score=%0d miss=%0d busy=%0b over=%0b mole=%b, want score=%0d miss=%0d busy=%0b over=%0b mole kind=%0d ref=%b",
                         mon_e.name, score, miss, busy, game_over, mole,
                         mon_e.score, mon_e.miss, mon_e.busy, mon_e.over, mon_e.mkind, mon_e.mref);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string name, input int s, input int m, input logic b,
                        input logic o, input int k, input logic [7:0] r);
        exp_t e;
        e.name  = name;
        e.at    = pcnt + 1;
        e.score = 8'(s);
        e.miss  = 8'(m);
        e.busy  = b;
        e.over  = o;
        e.mkind = k;
        e.mref  = r;
        q.push_back(e);
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int         s, m;
        logic       last, timeout_round;
        logic [7:0] lit, prev, wr;
        string      nm;

        step();
        push("reset_state", 0, 0, 0, 0, MK_ZERO, 8'd0);
        step();
        rst = 1'b1;
        step();

        // Game A: hits every round (one timed-out round when speed-up is built in)
        start = 1'b1;
        push("start_spawn", 0, 0, 1, 0, MK_ZERO, 8'd0);
        step();
        start = 1'b0;
        s = 0;
        m = 0;
        prev = 8'd0;
        for (int r = 0; r < TB_ROUNDS; r++) begin
            nm = (r == 0) ? "first_up" : "next_up_new_index";
            push(nm, s, m, 1, 0, (r == 0) ? MK_ONEHOT : MK_DIFF, prev);
            step();
            lit = mole;
            timeout_round = 1'b0;
`ifdef MOLE_SPEEDUP_EN
            timeout_round = (r == 4);
`endif
            if (timeout_round) begin
                do_ticks(6);
                push("speedup_lit_after6", s, m, 1, 0, MK_EXACT, lit);
                step();
                tick = 1'b1;
                push("speedup_timeout7", s, m + 1, 1, 0, MK_ZERO, 8'd0);
                step();
                tick = 1'b0;
                m = m + 1;
            end else begin
                btn = lit;
                push("hit", s + 1, m, 1, 0, MK_ZERO, 8'd0);
                step();
                s = s + 1;
                if (r == 0) begin
                    push("held_btn_1", s, m, 1, 0, MK_ZERO, 8'd0);
                    step();
                    push("held_btn_2", s, m, 1, 0, MK_ZERO, 8'd0);
                    step();
                end
                btn = 8'd0;
                step();
            end
            do_ticks(1);
            last = (r == TB_ROUNDS - 1);
            tick = 1'b1;
            nm = last ? "game_over" : "gap_to_spawn";
            push(nm, s, m, !last, last, MK_ZERO, 8'd0);
            step();
            tick = 1'b0;
            prev = lit;
        end

        // Game B: restart from OVER, then miss/priority/reset scenarios
        start = 1'b1;
        push("restart_clears", 0, 0, 1, 0, MK_ZERO, 8'd0);
        step();
        start = 1'b0;
        push("b1_up", 0, 0, 1, 0, MK_ONEHOT, 8'd0);
        step();
        lit = mole;
        wr  = {lit[6:0], lit[7]};
        btn = wr;
        push("wrong_press", 0, 1, 1, 0, MK_EXACT, lit);
        step();
        push("wrong_held", 0, 1, 1, 0, MK_EXACT, lit);
        step();
        btn = 8'd0;
        do_ticks(7);
        push("lit_after7", 0, 1, 1, 0, MK_EXACT, lit);
        step();
        tick = 1'b1;
        push("timeout8", 0, 2, 1, 0, MK_ZERO, 8'd0);
        step();
        tick = 1'b0;
        btn = 8'hFF;
        push("gap_press_ignored", 0, 2, 1, 0, MK_ZERO, 8'd0);
        step();
        btn = 8'd0;
        step();
        do_ticks(1);
        tick = 1'b1;
        push("b2_spawn", 0, 2, 1, 0, MK_ZERO, 8'd0);
        step();
        tick = 1'b0;
        prev = lit;
        push("b2_up_new_index", 0, 2, 1, 0, MK_DIFF, prev);
        step();
        lit = mole;
        wr  = {lit[6:0], lit[7]};
        do_ticks(7);
        btn  = lit | wr;
        tick = 1'b1;
        push("hit_beats_expiry", 1, 2, 1, 0, MK_ZERO, 8'd0);
        step();
        tick  = 1'b0;
        btn   = 8'd0;
        start = 1'b1;
        push("start_ignored_busy", 1, 2, 1, 0, MK_ZERO, 8'd0);
        step();
        start = 1'b0;
        do_ticks(1);
        tick = 1'b1;
        push("b3_spawn", 1, 2, 1, 0, MK_ZERO, 8'd0);
        step();
        tick = 1'b0;
        push("b3_up", 1, 2, 1, 0, MK_ONEHOT, 8'd0);
        step();

        // Short reset pulse that ends before the next falling clock edge
        push("async_reset_in_up", 0, 0, 0, 0, MK_ZERO, 8'd0);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        step();
        step();
        step();
        push("idle_after_reset", 0, 0, 0, 0, MK_ZERO, 8'd0);
        step();
        step();
        step();

        checks = checks + 1;
        if (q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mole_scheduler.md
MOLE_SCHEDULER -- requirements
Module: mole_scheduler

Interface
REQ-001 SHALL have parameter UP_TICKS, default 8, meaning number of ticks a mole stays lit (1..255).
REQ-002 SHALL have parameter GAP_TICKS, default 2, meaning number of dark ticks between moles (1..255).
REQ-003 SHALL have parameter ROUNDS, default 16, meaning moles per game (1..255).
REQ-004 SHALL have parameter MIN_UP_TICKS, default 2, meaning the floor for the lit time when speed-up is built in.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all flops update on the falling edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port tick, input, 1 bit: time-base strobe, one clk cycle wide.
REQ-008 SHALL have port start, input, 1 bit: start/restart request, sampled per cycle.
REQ-009 SHALL have port btn, input, 8 bits: debounced buttons, high = pressed.
REQ-010 SHALL have port mole, output, 8 bits: one-hot lit mole, all zero when none is lit.
REQ-011 SHALL have port score, output, 8 bits: correct hits, saturating at 255.
REQ-012 SHALL have port miss, output, 8 bits: timeouts plus wrong presses, saturating at 255.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE and OVER.
REQ-014 SHALL have port game_over, output, 1 bit: high only in OVER.

Function
REQ-015 SHALL run an FSM with states IDLE, SPAWN, UP, HIT, GAP and OVER; all outputs are registered.
REQ-016 SHALL run a free-running 8-bit Fibonacci LFSR, taps 8,6,5,4, advancing every cycle and never all-zero.
REQ-017 SHALL, in IDLE or OVER when start=1, clear score, miss and the round counter and go to SPAWN next cycle.
REQ-018 SHALL, in SPAWN (exactly 1 cycle), select index = lfsr[2:0], or index+1 mod 8 if that equals the previous round's index; load timer = current lit time; go to UP.
REQ-019 SHALL drive mole one-hot for the selected index throughout UP, and 0 in every other state.
REQ-020 SHALL detect presses as rising edges of btn against a 1-cycle registered copy; a held button counts once.
REQ-021 SHALL, in UP on a rising edge of the lit bit, increment score, load timer = GAP_TICKS and go to HIT.
REQ-022 SHALL, in UP on any rising edge of an unlit bit only, increment miss once per cycle and stay in UP.
REQ-023 SHALL, in UP when tick=1, decrement the timer; when the timer reaches 0, increment miss, load GAP_TICKS and go to GAP.
REQ-024 SHALL give a correct hit priority when it coincides with timer expiry or with wrong presses in the same cycle: score only, no miss.
REQ-025 SHALL pass through HIT in 1 cycle to GAP.
REQ-026 SHALL, in GAP, decrement the timer on tick; at 0, increment the round counter and go to OVER if it equals ROUNDS, else SPAWN.
REQ-027 SHALL ignore start while busy=1.
REQ-028 SHALL ignore btn edges outside UP.

Reset
REQ-029 SHALL, on rst low, asynchronously force state to IDLE; mole, score, miss, busy, game_over, the timer, the round counter, the previous index and the btn copy to 0; and the LFSR to 8'hA5.
REQ-030 SHALL, on reset mid-game, abandon the game and keep no score; after rst rises, the block waits in IDLE for start.

Configuration
REQ-031 SHALL, with macro MOLE_SPEEDUP_EN defined, reduce the lit time by 1 tick after every 4th correct hit, with a floor of MIN_UP_TICKS, and restore it to UP_TICKS on start.
REQ-032 SHALL, with MOLE_SPEEDUP_EN undefined, use a lit time of UP_TICKS for every round and build no speed-up logic.

Verification
REQ-033 SHALL cover: reset, then start pulse -> busy=1 after 1 cycle, SPAWN then UP, exactly one mole bit set, score=0, miss=0.
REQ-034 SHALL cover: in UP, press the lit button for 3 cycles -> score=1, HIT, mole=0; the held button produces no further counts.
REQ-035 SHALL cover: in UP, no press and 8 ticks -> miss=1, GAP entered; 2 more ticks -> SPAWN with an index different from the previous one.
REQ-036 SHALL cover: lit-button edge, a wrong-button edge and the final tick all in the same cycle -> score+1, miss unchanged.
REQ-037 SHALL cover: ROUNDS=3, all hits -> game_over=1 with score=3 and busy=0; start -> score=0 and a new game begins.
REQ-038 SHALL cover: rst asserted in UP -> mole=0 and score=0 immediately; with MOLE_SPEEDUP_EN defined, after 4 hits the lit time is 7 ticks.
